// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, instruction-memory req/ack fetch and next-PC selection.
// The fetcher runs a small FSM: IDLE -> FETCH -> EXEC -> FETCH ...
// Optional feature macro: PC_ALIGN_CHECK_EN. When it is defined, a misaligned next PC
// sends the unit to a FAULT state with a sticky pc_fault flag. When it is undefined,
// the low two bits of next PC are cleared instead.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 18,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [31:0]       im_rdata,
  input  logic              stall,
  input  logic              ctl_jump,
  input  logic              ctl_jr,
  input  logic              ctl_branch,
  input  logic              br_cond,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] link_pc,
  output logic              pc_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
`ifdef PC_ALIGN_CHECK_EN
    ,
    S_FAULT = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;

  logic [ADDR_W-1:0]        pc4;
  logic [ADDR_W-1:0]        jmp_tgt;
  logic signed [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0]        br_tgt;
  logic [ADDR_W-1:0]        next_raw;

  // Clears the byte-offset bits so the PC always points at a word.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  // Candidate targets: sequential, jump (region-relative), branch (PC-relative) and jr.
  always_comb begin
    pc4 = pc_q + ADDR_W'(4);

    // Jump: low bits come from the 26-bit index, bits above 27 keep the pc4 region.
    jmp_tgt = '0;
    for (int i = 2; i < ADDR_W; i++) begin
      if (i < 28) jmp_tgt[i] = instr_q[i-2];
      else        jmp_tgt[i] = pc4[i];
    end

    // Branch: sign-extended 16-bit word offset scaled to bytes.
    br_off = '0;
    for (int i = 2; i < ADDR_W; i++) begin
      if (i < 18) br_off[i] = instr_q[i-2];
      else        br_off[i] = instr_q[15];
    end
    br_tgt = pc4 + $unsigned(br_off);

    // Priority: jr, then jump, then taken branch, then fall-through.
    if (ctl_jr)                      next_raw = jr_target;
    else if (ctl_jump)               next_raw = jmp_tgt;
    else if (ctl_branch && br_cond)  next_raw = br_tgt;
    else                             next_raw = pc4;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic pc_fault_q, pc_fault_d;
`endif

  // Next-state, PC and instruction-register update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef PC_ALIGN_CHECK_EN
    pc_fault_d = pc_fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (im_ack) begin
          instr_d = im_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
          if (next_raw[1:0] != 2'b00) begin
            pc_fault_d = 1'b1;
            state_d    = S_FAULT;
          end else begin
            pc_d    = next_raw;
            state_d = S_FETCH;
          end
`else
          pc_d    = word_align(next_raw);
          state_d = S_FETCH;
`endif
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and instruction registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_fault_q <= 1'b0;
    else     pc_fault_q <= pc_fault_d;
  end
  assign pc_fault = pc_fault_q;
`else
  assign pc_fault = 1'b0;
`endif

  // Outputs decode directly from the registered state so reset drops im_req at once.
  always_comb begin
    im_req      = (state_q == S_FETCH);
    instr_valid = (state_q == S_EXEC);
    im_addr     = pc_q;
    pc_out      = pc_q;
    link_pc     = pc4;
    instr       = instr_q;
    opcode      = instr_q[31:26];
    funct       = instr_q[5:0];
  end

endmodule
